// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory request/response, and IF/ID pipeline register.
// The master modport is the fetch stage itself; the slave modport is the memory/decode environment.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_id_inst, if_id_pc, if_id_pc4, if_id_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: issues word-aligned imem requests and registers the result into IF/ID.
// Latency: one cycle from imem_ready to IF/ID; one instruction per cycle at zero wait states.
// Backpressure: stall holds IF/ID, a one-entry buffer catches an in-flight response; redirect overrides all.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [31:0] idpc_q, idpc_nxt;
    logic        vld_q, vld_nxt;
    logic [31:0] target;

    assign target          = {bus.redirect_pc[31:2], 2'b00};
    assign bus.if_id_inst  = inst_q;
    assign bus.if_id_pc    = idpc_q;
    assign bus.if_id_pc4   = idpc_q + 32'd4;
    assign bus.if_id_valid = vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= 32'd0;
            buf_inst  <= 32'd0;
            buf_pc    <= 32'd0;
            inst_q    <= NOP;
            idpc_q    <= 32'd0;
            vld_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop_addr <= drop_addr_nxt;
            buf_inst  <= buf_inst_nxt;
            buf_pc    <= buf_pc_nxt;
            inst_q    <= inst_nxt;
            idpc_q    <= idpc_nxt;
            vld_q     <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_addr_nxt = drop_addr;
        buf_inst_nxt  = buf_inst;
        buf_pc_nxt    = buf_pc;
        inst_nxt      = inst_q;
        idpc_nxt      = idpc_q;
        vld_nxt       = vld_q;
        // Request is masked during reset so the bus sees no request until release.
        bus.imem_req  = rst && (state != HOLD);
        bus.imem_addr = (state == DISCARD) ? drop_addr : pc;

        case (state)
            FETCH: begin
                if (bus.redirect) begin
                    pc_nxt   = target;
                    inst_nxt = NOP;
                    vld_nxt  = 1'b0;
                    // The outstanding request must still complete at its original address.
                    if (!bus.imem_ready) begin
                        drop_addr_nxt = pc;
                        state_nxt     = DISCARD;
                    end
                end else if (bus.imem_ready) begin
                    pc_nxt = pc + 32'd4;
                    if (bus.stall) begin
                        buf_inst_nxt = bus.imem_rdata;
                        buf_pc_nxt   = pc;
                        state_nxt    = HOLD;
                    end else begin
                        inst_nxt = bus.imem_rdata;
                        idpc_nxt = pc;
                        vld_nxt  = 1'b1;
                    end
                end else if (!bus.stall) begin
                    inst_nxt = NOP;
                    vld_nxt  = 1'b0;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_nxt    = target;
                    inst_nxt  = NOP;
                    vld_nxt   = 1'b0;
                    state_nxt = FETCH;
                end else if (!bus.stall) begin
                    inst_nxt  = buf_inst;
                    idpc_nxt  = buf_pc;
                    vld_nxt   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (bus.redirect) begin
                    pc_nxt   = target;
                    inst_nxt = NOP;
                    vld_nxt  = 1'b0;
                end
                if (bus.imem_ready) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr^0xA5, expected IF/ID entries are queued as stimulus is driven.
module tb_fetch_stage;
    logic clk;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = bus.imem_addr ^ 32'h0000_00A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_t e;
        e.pc   = p;
        e.inst = p ^ 32'h0000_00A5;
        q.push_back(e);
    endtask

    // Advance one edge; a valid output following an unstalled edge is a new instruction.
    task automatic tick();
        logic s;
        exp_t e;
        s = bus.stall;
        @(posedge clk);
        #1;
        if (!s && bus.if_id_valid === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_extra: observed pc %08h expected no instruction", bus.if_id_pc);
                end
            end else begin
                e = q.pop_front();
                chk("sb_inst", bus.if_id_inst, e.inst);
                chk("sb_pc", bus.if_id_pc, e.pc);
                chk("sb_pc4", bus.if_id_pc4, e.pc + 32'd4);
            end
        end
    endtask

    initial begin
        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_inst", bus.if_id_inst, 32'h0000_0013);
        chk("rst_pc", bus.if_id_pc, 32'd0);
        chk("rst_pc4", bus.if_id_pc4, 32'd4);
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rel_addr", bus.imem_addr, 32'd0);

        // Zero-wait streaming
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", {31'd0, bus.if_id_valid}, 32'd1);
        end
        chk("stream_addr", bus.imem_addr, 32'h10);

        // Asynchronous reset while a request waits
        bus.imem_ready = 1'b0;
        tick();
        chk("wait_addr", bus.imem_addr, 32'h10);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("arst_pc", bus.if_id_pc, 32'd0);
        chk("arst_inst", bus.if_id_inst, 32'h0000_0013);
        tick();
        chk("arst_hold_req", {31'd0, bus.imem_req}, 32'd0);
        rst            = 1'b1;
        bus.imem_ready = 1'b1;
        #1;
        chk("arst_rel_addr", bus.imem_addr, 32'd0);

        // Two wait states at address 8
        push(32'h0); push(32'h4);
        tick();
        tick();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ws_valid", {31'd0, bus.if_id_valid}, 32'd0);
            chk("ws_inst", bus.if_id_inst, 32'h0000_0013);
            chk("ws_addr", bus.imem_addr, 32'h8);
            chk("ws_req", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ready = 1'b1;
        push(32'h8);
        tick();

        // Stall for three cycles while 0x10 returns
        push(32'hC);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.if_id_pc, 32'hC);
            chk("stall_inst", bus.if_id_inst, 32'hC ^ 32'hA5);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.stall = 1'b0;
        push(32'h10);
        tick();
        chk("unstall_addr", bus.imem_addr, 32'h14);

        // Redirect while the request at 0x20 is outstanding
        push(32'h14); push(32'h18); push(32'h1C);
        tick(); tick(); tick();
        bus.imem_ready = 1'b0;
        tick();
        chk("pre_redir_addr", bus.imem_addr, 32'h20);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        tick();
        bus.redirect = 1'b0;
        chk("disc_addr", bus.imem_addr, 32'h20);
        chk("disc_valid", {31'd0, bus.if_id_valid}, 32'd0);
        tick();
        chk("disc2_addr", bus.imem_addr, 32'h20);
        bus.imem_ready = 1'b1;
        tick();
        chk("disc_done_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("target_addr", bus.imem_addr, 32'h100);
        push(32'h100);
        tick();

        // Redirect during a stalled HOLD
        bus.stall = 1'b1;
        tick();
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        chk("hold_redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("hold_redir_inst", bus.if_id_inst, 32'h0000_0013);
        chk("hold_redir_addr", bus.imem_addr, 32'h200);
        push(32'h200);
        tick();

        // Redirect with a ready response, then PC wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        bus.redirect = 1'b0;
        chk("wrap_redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        tick();
        chk("wrapped_addr", bus.imem_addr, 32'h0);
        push(32'h0);
        tick();

        chk("sb_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
